// File: rtl/scope_trace_renderer.sv
// scope_trace_renderer
//   Scrolling multi-channel waveform renderer. Generates VGA timing on the
//   pixel clock, keeps one sample word per screen column in a ring buffer and
//   draws every channel as a coloured trace over a black field with a white
//   centre line. Supports run, hold and single-shot trigger capture.
//
// Ports
//   clk            pixel clock, single clock domain
//   rst_n          synchronous active-low reset
//   sample_valid   sample word present on sample_data
//   sample_ready   sample word accepted this cycle (from mode/state only)
//   sample_data    channel c at [c*SAMPLE_W +: SAMPLE_W]
//   mode           0 run, 1 hold, 2 trigger, 3 hold
//   trig_level     rising-edge threshold on channel 0
//   trig_rearm     one-cycle pulse re-arming the trigger in mode 2
//   frame_start    pulse at H=0,V=0 of the undelayed counters
//   trig_state     0 idle, 1 armed, 2 capture, 3 done
//   Hsynq, Vsynq   active-high sync, aligned with colour
//   Red/Green/Blue RGB444 pixel colour
module scope_trace_renderer #(
  parameter int SAMPLE_W    = 8,
  parameter int CHANNELS    = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int TRACE_THICK = 2,
  parameter logic [CHANNELS*12-1:0] CH_COLORS = {12'hFF0, 12'h0F0}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic [1:0]                   mode,
  input  logic [SAMPLE_W-1:0]          trig_level,
  input  logic                         trig_rearm,
  output logic                         frame_start,
  output logic [1:0]                   trig_state,
  output logic                         Hsynq,
  output logic                         Vsynq,
  output logic [3:0]                   Red,
  output logic [3:0]                   Green,
  output logic [3:0]                   Blue
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(H_ACTIVE);
  localparam int FW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + TRACE_THICK + 1);
  localparam int DW = CHANNELS * SAMPLE_W;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [AW:0]   H_ACT_A   = (AW+1)'(H_ACTIVE);
  localparam logic [AW-1:0] PTR_LAST  = AW'(H_ACTIVE - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(H_ACTIVE);
  localparam logic [FW-1:0] FILL_LAST = FW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MID     = YW'(V_ACTIVE / 2);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    TS_IDLE    = 2'd0,
    TS_ARMED   = 2'd1,
    TS_CAPTURE = 2'd2,
    TS_DONE    = 2'd3
  } ts_t;

  // True when screen row y falls inside the trace band of sample s.
  // Full-width product so the scaling never overflows.
  function automatic logic trace_hit(input logic [SAMPLE_W-1:0] s,
                                     input logic [YW-1:0] y);
    logic [SAMPLE_W+YW-1:0] prod;
    logic [YW-1:0]          row;
    prod = (SAMPLE_W+YW)'(s) * (SAMPLE_W+YW)'(V_ACTIVE);
    row  = Y_LAST - YW'(prod >> SAMPLE_W);
    return (y >= row) && ({1'b0, y} < ({1'b0, row} + (YW+1)'(TRACE_THICK)));
  endfunction

  logic [HW-1:0]       h_cnt;
  logic [VW-1:0]       v_cnt;
  ts_t                 state, state_nx;
  logic [AW-1:0]       wr_ptr, base;
  logic [FW-1:0]       fill, fill_f;
  logic [SAMPLE_W-1:0] prev0;
  logic [SAMPLE_W-1:0] s0;
  logic                accept, trig_hit, wr_en, arm;
  logic [DW-1:0]       mem [H_ACTIVE];

  // stage 0: counters, sync, active window, read address
  logic          hs_p0, vs_p0, vld_p0, empty_p0;
  logic [AW-1:0] x_p0, rd_addr_p0;
  logic [YW-1:0] y_p0;
  logic [AW:0]   addr_sum_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign frame_start = rst_n && (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    hs_p0  = h_cnt < H_SYNC_C;
    vs_p0  = v_cnt < V_SYNC_C;
    vld_p0 = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
             (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    x_p0   = AW'(h_cnt - H_ACT_BEG);
    y_p0   = YW'(v_cnt - V_ACT_BEG);
    // (base + x) mod H_ACTIVE; both terms are below H_ACTIVE so one subtract suffices
    addr_sum_p0 = {1'b0, base} + {1'b0, x_p0};
    rd_addr_p0  = (addr_sum_p0 >= H_ACT_A) ? AW'(addr_sum_p0 - H_ACT_A) : AW'(addr_sum_p0);
    // columns left of the oldest stored sample stay blank
    empty_p0 = ({1'b0, FW'(x_p0)} + {1'b0, fill_f}) < {1'b0, FILL_MAX};
  end

  assign s0       = sample_data[SAMPLE_W-1:0];
  assign accept   = sample_valid && sample_ready;
  assign trig_hit = (prev0 < trig_level) && (trig_level <= s0);
  assign trig_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= TS_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mode != 2'd2) begin
      state_nx = TS_IDLE;
    end else if ((state == TS_IDLE) || trig_rearm) begin
      state_nx = TS_ARMED;
    end else begin
      case (state)
        TS_ARMED:   if (accept && trig_hit) state_nx = TS_CAPTURE;
        // the triggering write made fill 1, so fill counts capture writes
        TS_CAPTURE: if (accept && (fill == FILL_LAST)) state_nx = TS_DONE;
        default:    ;
      endcase
    end
  end

  always_comb begin
    sample_ready = 1'b0;
    arm          = 1'b0;
    wr_en        = 1'b0;
    case (mode)
      2'd0: begin
        sample_ready = 1'b1;
        wr_en        = sample_valid;
      end
      2'd2: begin
        sample_ready = (state == TS_ARMED) || (state == TS_CAPTURE);
        arm          = (state == TS_IDLE) || trig_rearm;
        // rearm wins over a simultaneous sample; armed samples only feed prev0
        wr_en        = sample_valid && sample_ready && !trig_rearm &&
                       ((state == TS_CAPTURE) || ((state == TS_ARMED) && trig_hit));
      end
      default: ;
    endcase
  end

  // snapshot is taken from pre-write values, so a write at frame_start lands next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
      prev0  <= '0;
      base   <= '0;
      fill_f <= '0;
    end else begin
      if (frame_start) begin
        base   <= wr_ptr;
        fill_f <= fill;
      end
      if (accept) prev0 <= s0;
      if (arm) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

  // stage 1: RAM read data, row compare
  logic          hs_p1, vs_p1, vld_p1, empty_p1;
  logic [YW-1:0] y_p1;
  logic [DW-1:0] rd_data_p1;
  logic [11:0]   pix_p1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_data;
    rd_data_p1 <= mem[rd_addr_p0];
    y_p1       <= y_p0;
    empty_p1   <= empty_p0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= vld_p0;
    end
  end

  always_comb begin
    pix_p1 = '0;
    if (vld_p1) begin
      if (y_p1 == Y_MID) pix_p1 = 12'hFFF;
      if (!empty_p1) begin
        // descending so the lowest-index lit channel is assigned last and wins
        for (int c = CHANNELS - 1; c >= 0; c--) begin
          if (trace_hit(rd_data_p1[c*SAMPLE_W +: SAMPLE_W], y_p1))
            pix_p1 = CH_COLORS[c*12 +: 12];
        end
      end
    end
  end

  // stage 2: registered colour and sync
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
      Hsynq <= 1'b0;
      Vsynq <= 1'b0;
    end else begin
      Red   <= pix_p1[11:8];
      Green <= pix_p1[7:4];
      Blue  <= pix_p1[3:0];
      Hsynq <= hs_p1;
      Vsynq <= vs_p1;
    end
  end

endmodule

// File: tb/tb_scope_trace_renderer.sv
module tb_scope_trace_renderer;

  localparam int SW = 8, CH = 2, TH = 2;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int FRAME = HT * VT;
  localparam logic [CH*12-1:0] COLORS = {12'hFF0, 12'h0F0};

  logic            clk, rst_n;
  logic            sample_valid, sample_ready;
  logic [CH*SW-1:0] sample_data;
  logic [1:0]      mode;
  logic [SW-1:0]   trig_level;
  logic            trig_rearm;
  logic            frame_start;
  logic [1:0]      trig_state;
  logic            Hsynq, Vsynq;
  logic [3:0]      Red, Green, Blue;

  scope_trace_renderer #(
    .SAMPLE_W(SW), .CHANNELS(CH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .TRACE_THICK(TH), .CH_COLORS(COLORS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .mode(mode),
    .trig_level(trig_level), .trig_rearm(trig_rearm),
    .frame_start(frame_start), .trig_state(trig_state),
    .Hsynq(Hsynq), .Vsynq(Vsynq),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CH*12-1:0] colors_v = COLORS;
  int               m_h, m_v, m_st, m_wp, m_fill, m_base, m_fill_f, m_prev0, m_cap;
  logic [CH*SW-1:0] m_mem [HA];
  logic [13:0]      exp_q [$];
  bit               started = 0;

  function automatic logic [11:0] ref_pixel(input int x, input int y);
    logic [CH*SW-1:0] word;
    int s, row;
    if (x >= HA - m_fill_f) begin
      word = m_mem[(m_base + x) % HA];
      for (int c = 0; c < CH; c++) begin
        s   = int'(word[c*SW +: SW]);
        row = (VA - 1) - (s * VA) / (1 << SW);
        if (y >= row && y < row + TH) return colors_v[c*12 +: 12];
      end
    end
    if (y == VA / 2) return 12'hFFF;
    return 12'h000;
  endfunction

  function automatic logic [13:0] ref_out(input int h, input int v);
    int x, y;
    logic [11:0] pix;
    x = h - (HS + HBP);
    y = v - (VS + VBP);
    pix = 12'h000;
    if (x >= 0 && x < HA && y >= 0 && y < VA) pix = ref_pixel(x, y);
    return {(h < HS), (v < VS), pix};
  endfunction

  function automatic logic ref_ready();
    return (mode == 2'd0) || (mode == 2'd2 && (m_st == 1 || m_st == 2));
  endfunction

  always @(posedge clk) begin
    logic acc, commit, do_arm;
    int s0;
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_st = 0; m_wp = 0; m_fill = 0;
      m_base = 0; m_fill_f = 0; m_prev0 = 0; m_cap = 0;
      exp_q.delete();
      exp_q.push_back(14'h0);
      exp_q.push_back(14'h0);
      started = 1;
    end else begin
      exp_q.push_back(ref_out(m_h, m_v));
      s0 = int'(sample_data[SW-1:0]);
      acc = sample_valid && ref_ready();
      commit = 0;
      do_arm = 0;
      if (mode == 2'd0) begin
        commit = acc;
        m_st = 0;
      end else if (mode != 2'd2) begin
        m_st = 0;
      end else if (m_st == 0 || trig_rearm) begin
        m_st = 1;
        do_arm = 1;
      end else if (m_st == 1) begin
        if (acc && m_prev0 < int'(trig_level) && int'(trig_level) <= s0) begin
          m_st = 2; commit = 1; m_cap = 1;
        end
      end else if (m_st == 2) begin
        if (acc) begin
          commit = 1;
          m_cap++;
          if (m_cap == HA) m_st = 3;
        end
      end
      if (m_h == 0 && m_v == 0) begin
        m_base = m_wp;
        m_fill_f = m_fill;
      end
      if (acc) m_prev0 = s0;
      if (do_arm) begin
        m_wp = 0; m_fill = 0;
      end else if (commit) begin
        m_mem[m_wp] = sample_data;
        m_wp = (m_wp + 1) % HA;
        if (m_fill < HA) m_fill++;
      end
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v + 1) % VT;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [13:0] e;
    if (started) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pixel_sync", {18'h0, Hsynq, Vsynq, Red, Green, Blue}, {18'h0, e});
      end
      chk("sample_ready", {31'h0, sample_ready}, {31'h0, ref_ready()});
      chk("trig_state", {30'h0, trig_state}, 32'(m_st));
      chk("frame_start", {31'h0, frame_start},
          {31'h0, (rst_n && m_h == 0 && m_v == 0)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input int valid_pct, input bit rnd_data,
                            input logic [CH*SW-1:0] fixed);
    for (int i = 0; i < n; i++) begin
      sample_valid = ($urandom_range(99) < valid_pct);
      sample_data  = rnd_data ? (CH*SW)'($urandom) : fixed;
      tick();
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
    mode = 2'd0; trig_level = '0; trig_rearm = 1'b0;
    tick();
    tick();
    chk("reset_trig_state", {30'h0, trig_state}, 32'd0);
    chk("reset_rgb", {20'h0, Red, Green, Blue}, 32'h0);
    chk("reset_sync", {30'h0, Hsynq, Vsynq}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("first_frame_start", {31'h0, frame_start}, 32'd1);

    // run mode, constant mid-scale on both channels
    mode = 2'd0;
    run_cycles(3 * FRAME, 100, 1'b0, {8'h80, 8'h80});
    // run mode, random data and valid
    run_cycles(2 * FRAME, 50, 1'b1, '0);

    // partial fill after reset
    reset_pulse();
    run_cycles(5, 100, 1'b0, '0);
    run_cycles(2 * FRAME, 0, 1'b0, '0);

    // hold mode
    mode = 2'd1;
    run_cycles(3 * FRAME, 100, 1'b1, '0);
    chk("hold_ready", {31'h0, sample_ready}, 32'd0);

    // trigger mode, ramp on channel 0
    mode = 2'd2; trig_level = 8'h40; sample_valid = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      sample_valid = 1'b1;
      sample_data  = {8'($urandom), 8'(i)};
      tick();
      if (i == 8'h3F) chk("ramp_before_trig", {30'h0, trig_state}, 32'd1);
      if (i == 8'h40) chk("ramp_at_trig", {30'h0, trig_state}, 32'd2);
    end
    chk("ramp_done", {30'h0, trig_state}, 32'd3);
    chk("ramp_done_ready", {31'h0, sample_ready}, 32'd0);
    run_cycles(FRAME, 0, 1'b0, '0);
    trig_rearm = 1'b1;
    tick();
    trig_rearm = 1'b0;
    chk("rearm_state", {30'h0, trig_state}, 32'd1);
    run_cycles(FRAME + 5, 0, 1'b0, '0);

    // random trigger traffic with rearms and mode changes
    for (int blk = 0; blk < 8; blk++) begin
      n = $urandom_range(9);
      mode = (n < 6) ? 2'd2 : 2'(n - 6);
      trig_level = 8'($urandom);
      for (int i = 0; i < 200; i++) begin
        sample_valid = ($urandom_range(3) != 0);
        sample_data  = (CH*SW)'($urandom);
        trig_rearm   = ($urandom_range(63) == 0);
        tick();
      end
      trig_rearm = 1'b0;
    end

    // reset in the middle of a capture, in the middle of a line
    mode = 2'd1; sample_valid = 1'b0;
    tick();
    mode = 2'd2; trig_level = 8'h40;
    tick();
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      sample_valid = 1'b1;
      sample_data  = {8'($urandom), 8'(i)};
      tick();
      seen = (trig_state == 2'd2);
    end
    chk("capture_reached", {31'h0, seen}, 32'd1);
    seen = 0;
    for (int i = 0; i < 2 * HT && !seen; i++) begin
      sample_data = {8'($urandom), 8'(8'h48 + i)};
      tick();
      seen = (m_h == HT / 2);
    end
    chk("midline_reached", {31'h0, seen}, 32'd1);
    sample_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midcap_reset_state", {30'h0, trig_state}, 32'd0);
    chk("midcap_reset_rgb", {20'h0, Red, Green, Blue}, 32'h0);
    chk("midcap_reset_sync", {30'h0, Hsynq, Vsynq}, 32'h0);
    chk("midcap_reset_ready", {31'h0, sample_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midcap_frame_start", {31'h0, frame_start}, 32'd1);
    run_cycles(FRAME + 5, 0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_trace_renderer.md
# scope_trace_renderer

Parametrised, multi-channel scrolling waveform renderer for the oscilloscope display path. It generates VGA timing on a single pixel clock and stores one sample per screen column per channel in an on-chip ring buffer. It draws each channel as a coloured trace over a black field with a white centre line. It supports run, hold and single-shot trigger modes. It sits between the ADC/sample-decimation stage (valid/ready source) and the VGA connector pins.

## Interface
- SAMPLE_W, 8: bits per channel sample (unsigned, 0 = bottom of screen).
- CHANNELS, 2: number of traces, 1..4.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- TRACE_THICK, 2: trace height in rows, 1..8.
- CH_COLORS, {12'hFF0, 12'h0F0}: packed 12-bit RGB444 per channel; channel 0 occupies bits [11:0].

Ports:
- clk  in  1  pixel clock (25 MHz for defaults); single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  sample word present.
- sample_ready  out  1  block accepts the sample word this cycle.
- sample_data  in  CHANNELS*SAMPLE_W  channel c at [c*SAMPLE_W +: SAMPLE_W].
- mode  in  2  0 run, 1 hold, 2 trigger, 3 treated as hold.
- trig_level  in  SAMPLE_W  rising-edge threshold on channel 0.
- trig_rearm  in  1  one-cycle pulse to re-arm in trigger mode.
- frame_start  out  1  one-cycle pulse at H=0, V=0 (undelayed counters).
- trig_state  out  2  0 idle, 1 armed, 2 capture, 3 done.
- Hsynq, Vsynq  out  1  active-high sync.
- Red, Green, Blue  out  4 each  pixel colour.

## Operation
- Counters: H counts 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800 at defaults). V increments when H wraps and counts 0..V_TOTAL-1 (525 at defaults).
- Sync and active region:
  - Raw Hsynq is high for H < H_SYNC; raw Vsynq is high for V < V_SYNC.
  - Active region: H in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), V in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x and y are the offsets into the active region.
- Buffer: CHANNELS × H_ACTIVE words of SAMPLE_W bits, with a single write pointer wr_ptr (0..H_ACTIVE-1, wraps) and a fill count fill (0..H_ACTIVE, saturates).
- Write: on an accepted, committed sample, write all channels at wr_ptr, advance wr_ptr, and increment fill.
- Frame snapshot: at frame_start, latch base = wr_ptr and fill_f = fill. These values are used for the whole frame, so there is no mid-frame scroll tear.
- Read address: (base + x) mod H_ACTIVE, computed without a divider via a compare-and-subtract. Oldest sample is at the left, newest at the right.
- Columns with x < H_ACTIVE − fill_f contain no trace.
- Row mapping: row_c = (V_ACTIVE−1) − ((s_c × V_ACTIVE) >> SAMPLE_W). Use a full-width product, with no overflow.
- Channel c is lit when row_c ≤ y < row_c+TRACE_THICK; rows beyond V_ACTIVE−1 are clipped.
- Pixel priority: lowest-index lit channel, then the centre line (y == V_ACTIVE/2, colour 12'hFFF), then black. Outside the active region the pixel is black.
- sample_ready:
  - Mode 0: always high.
  - Modes 1 and 3: low.
  - Mode 2: high in armed and capture states, low in idle and done.
- Trigger FSM (only active in mode 2):
  - idle → armed on entry to mode 2 or on trig_rearm. Arming clears fill to 0 and wr_ptr to 0.
  - armed: accepted samples are not written; prev0 tracks channel 0. Go to capture when prev0 < trig_level ≤ s0. That triggering sample is written as the first sample.
  - capture: write every accepted sample. After H_ACTIVE writes, go to done.
  - done: hold.
  - Any state → idle when mode ≠ 2. Buffer contents, fill and wr_ptr are retained.
- Simultaneous events:
  - trig_rearm together with an accepted sample: rearm wins; the sample is only loaded into prev0.
  - A write in the same cycle as frame_start is latched into the next frame, not the current one.
- Reset: rst_n low for one clk edge returns all state to its reset value, including mid-frame or mid-capture. Buffer RAM is not cleared; fill = 0 hides its contents.

## Timing
- Pixel pipeline has 2 cycles latency:
  - Cycle 0: counters and read address.
  - Cycle 1: RAM read data, row compare.
  - Cycle 2: registered Red/Green/Blue.
- Hsynq and Vsynq pass through the same 2-stage delay, so colour and sync stay aligned.
- frame_start is undelayed.
- Handshake: a transfer occurs on a rising edge with sample_valid && sample_ready. sample_ready is combinational from mode and FSM state only, never from sample_valid. One sample per cycle maximum.
- Reset values:
  - H, V, wr_ptr, fill, base, fill_f, prev0 = 0.
  - trig_state = idle.
  - Red, Green, Blue = 0; Hsynq, Vsynq = 0; both sync pipeline stages = 0.
  - frame_start = 0.
- First cycle after reset: H = 0, V = 0 and frame_start = 1. Delayed Hsynq first rises 2 cycles after reset release.

## Test plan
- Sync timing, defaults: Hsynq high 96 of every 800 cycles and Vsynq high 2 of every 525 lines. Both are offset by 2 cycles from frame_start.
- Run mode, both channels fed 0x80 for 700 samples: every column shows channel 0 green on rows 239–240 (0x0F0), winning over the centre line at row 240. Row 241 is black.
- Partial fill: 100 accepted samples of 0x00 after reset. Columns 0–539 are black except the centre line; columns 540–639 are green at row 479 only (clipped).
- Hold mode with sample_valid held high: sample_ready = 0, and the frame is bit-identical across 3 frames.
- Trigger mode, trig_level 0x40, ramp input 0x00..0xFF on channel 0: trig_state goes 1→2 at the sample equal to 0x40. Column 0 shows 0x40 once the capture completes. After 640 writes trig_state = 3 and sample_ready = 0. trig_rearm returns trig_state to 1 and blanks the traces.
- Reset asserted mid-capture (mid-line): the next cycle shows all registers at their reset values, the screen has no trace, and trig_state = 0.
